mod_pow4_seq: RTL and testbench

MOD_POW4_SEQ -- requirements
Module: mod_pow4_seq

---
 rtl/mod_pow4_pkg.sv | 12 +
 rtl/mod_quad_step.sv | 26 ++
 rtl/mod_pow4_seq.sv | 114 +++++++++++
 tb/tb_mod_pow4_seq.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mod_pow4_pkg.sv
// Shared types and constants for the modular power-of-four sequencer.
package mod_pow4_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } stateT;

   localparam int EXPW_DEF = 4;

endpackage

// File: rtl/mod_quad_step.sv
// One combinational step r = (4*a) mod q, built from two modular doublings.
// Requires a < q; each doubling then needs at most one subtract of q.
module mod_quad_step #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r
);

   logic [WIDTH:0] dbl1;
   logic [WIDTH:0] red1;
   logic [WIDTH:0] dbl2;
   logic [WIDTH:0] red2;
   logic [WIDTH:0] qExt;

   always_comb begin
      qExt = {1'b0, q};
      dbl1 = {a, 1'b0};
      red1 = (dbl1 >= qExt) ? (dbl1 - qExt) : dbl1;
      dbl2 = {red1[WIDTH-1:0], 1'b0};
      red2 = (dbl2 >= qExt) ? (dbl2 - qExt) : dbl2;
      r    = red2[WIDTH-1:0];
   end

endmodule

// File: rtl/mod_pow4_seq.sv
// Sequential (x * 4^k) mod q with valid/ready handshakes on both sides.
// Optional MOD_POW4_SEQ_ABORT_EN adds an iAbort input that cancels RUN/DONE.
//
// state | meaning
// IDLE  | waiting for a request, oReady high
// RUN   | one quadrupling step per cycle until cnt reaches zero
// DONE  | result/error presented with oValid until iReady
`ifndef BITWIDTH
`define BITWIDTH 8
`endif

module mod_pow4_seq
   import mod_pow4_pkg::*;
#(
   parameter int WIDTH = `BITWIDTH,
   parameter int EXPW  = EXPW_DEF
) (
   input  logic             iClk,
   input  logic             iRstN,
   input  logic             iValid,
   output logic             oReady,
   input  logic [WIDTH-1:0] iData,
   input  logic [WIDTH-1:0] iQ,
   input  logic [EXPW-1:0]  iExp,
   output logic             oValid,
   input  logic             iReady,
   output logic [WIDTH-1:0] oData,
   output logic             oErr,
   output logic             oBusy
`ifdef MOD_POW4_SEQ_ABORT_EN
   ,
   input  logic             iAbort
`endif
);

   stateT            state;
   stateT            stateNxt;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] qR;
   logic [EXPW-1:0]  cnt;
   logic             errR;
   logic [WIDTH-1:0] stepR;
   logic             reqErr;
   logic             abortHit;

   mod_quad_step #(.WIDTH(WIDTH)) uStep (
      .a (acc),
      .q (qR),
      .r (stepR)
   );

   always_comb begin
      reqErr = (iQ < WIDTH'(2)) || (iData >= iQ);
`ifdef MOD_POW4_SEQ_ABORT_EN
      abortHit = iAbort && (state != IDLE);
`else
      abortHit = 1'b0;
`endif
   end

   always_ff @(posedge iClk) begin
      if (!iRstN) begin
         state <= IDLE;
         acc   <= '0;
         qR    <= '0;
         cnt   <= '0;
         errR  <= 1'b0;
      end else begin
         state <= stateNxt;
         if (abortHit) begin
            acc  <= '0;
            cnt  <= '0;
            errR <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (iValid) begin
                     qR   <= iQ;
                     cnt  <= iExp;
                     errR <= reqErr;
                     acc  <= reqErr ? '0 : iData;
                  end
               end
               RUN: begin
                  acc <= stepR;
                  cnt <= cnt - EXPW'(1);
               end
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      stateNxt = state;
      case (state)
         IDLE: if (iValid) stateNxt = (reqErr || (iExp == '0)) ? DONE : RUN;
         RUN:  if (cnt == EXPW'(1)) stateNxt = DONE;
         DONE: if (iReady) stateNxt = IDLE;
         default: stateNxt = IDLE;
      endcase
      if (abortHit) stateNxt = IDLE;
   end

   // Result and error are gated so nothing leaks out while not in DONE.
   always_comb begin
      oReady = (state == IDLE);
      oBusy  = (state != IDLE);
      oValid = (state == DONE);
      oData  = oValid ? acc : '0;
      oErr   = oValid && errR;
   end

endmodule

// File: tb/tb_mod_pow4_seq.sv
// Randomized self-checking bench for mod_pow4_seq against an arithmetic model.
module tb_mod_pow4_seq;

   localparam int WIDTH = 8;
   localparam int EXPW  = 4;
   localparam int MAXLAT = 40;

   logic             iClk = 1'b0;
   logic             iRstN = 1'b0;
   logic             iValid = 1'b0;
   logic             oReady;
   logic [WIDTH-1:0] iData = '0;
   logic [WIDTH-1:0] iQ = '0;
   logic [EXPW-1:0]  iExp = '0;
   logic             oValid;
   logic             iReady = 1'b0;
   logic [WIDTH-1:0] oData;
   logic             oErr;
   logic             oBusy;
`ifdef MOD_POW4_SEQ_ABORT_EN
   logic             iAbort = 1'b0;
`endif

   int nChecks = 0;
   int nErrors = 0;

   mod_pow4_seq #(.WIDTH(WIDTH), .EXPW(EXPW)) dut (
      .iClk   (iClk),
      .iRstN  (iRstN),
      .iValid (iValid),
      .oReady (oReady),
      .iData  (iData),
      .iQ     (iQ),
      .iExp   (iExp),
      .oValid (oValid),
      .iReady (iReady),
      .oData  (oData),
      .oErr   (oErr),
      .oBusy  (oBusy)
`ifdef MOD_POW4_SEQ_ABORT_EN
      ,
      .iAbort (iAbort)
`endif
   );

   always #5 iClk = ~iClk;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got !== exp) begin
         nErrors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference: (x * 4^k) mod q in plain arithmetic; 4^15 * 255 fits in longint.
   function automatic logic [WIDTH-1:0] refPow4(input int x, input int q, input int k);
      longint p;
      p = longint'(x) * (longint'(1) << (2 * k));
      return WIDTH'(p % longint'(q));
   endfunction

   task automatic tick();
      @(posedge iClk);
      #1;
   endtask

   // Issue one request, then wait for and check the result, holding iReady low
   // for holdCycles cycles once oValid appears.
   task automatic runReq(input int x, input int q, input int k, input int holdCycles);
      bit   isErr;
      int   lat;
      int   expLat;
      logic [WIDTH-1:0] expData;
      isErr   = (q < 2) || (x >= q);
      expData = isErr ? '0 : refPow4(x, q, k);
      expLat  = (isErr || k == 0) ? 1 : k + 1;
      checkVal("ready_before_req", oReady, 1);
      iValid = 1'b1;
      iData  = WIDTH'(x);
      iQ     = WIDTH'(q);
      iExp   = EXPW'(k);
      iReady = (holdCycles == 0);
      tick();
      lat = 1;
      while (!oValid && lat < MAXLAT) begin
         iValid = 1'($urandom);
         iData  = WIDTH'($urandom);
         iQ     = WIDTH'($urandom);
         iExp   = EXPW'($urandom);
         checkVal("ready_low_busy", oReady, 0);
         tick();
         lat++;
      end
      iValid = 1'b0;
      checkVal("result_timeout", (lat < MAXLAT), 1);
      checkVal("latency", lat, expLat);
      checkVal("odata", oData, expData);
      checkVal("oerr", oErr, isErr);
      for (int i = 0; i < holdCycles; i++) begin
         tick();
         checkVal("hold_valid", oValid, 1);
         checkVal("hold_data", oData, expData);
         checkVal("hold_err", oErr, isErr);
         checkVal("hold_ready", oReady, 0);
      end
      iReady = 1'b1;
      tick();
      checkVal("valid_dropped", oValid, 0);
      checkVal("ready_after", oReady, 1);
      checkVal("busy_after", oBusy, 0);
   endtask

   initial begin
      int x;
      int q;
      int k;
      int sawValid;

      iRstN = 1'b0;
      tick();
      tick();
      checkVal("rst_valid", oValid, 0);
      checkVal("rst_busy", oBusy, 0);
      checkVal("rst_data", oData, 0);
      checkVal("rst_err", oErr, 0);
      iRstN = 1'b1;
      tick();
      checkVal("rst_ready", oReady, 1);

      runReq(10, 23, 1, 0);
      runReq(10, 23, 3, 0);
      runReq(10, 14, 1, 0);
      runReq(10, 23, 0, 0);
      runReq(10, 23, 2, 5);
      runReq(25, 23, 2, 0);
      runReq(10, 1, 3, 0);
      runReq(0, 2, 4, 1);
      runReq(254, 255, 15, 0);
      runReq(5, 5, 1, 0);

      // Reset in the middle of a long run discards it.
      iValid = 1'b1;
      iData = 8'd10;
      iQ = 8'd23;
      iExp = 4'd15;
      iReady = 1'b1;
      tick();
      iValid = 1'b0;
      tick();
      tick();
      iRstN = 1'b0;
      tick();
      iRstN = 1'b1;
      checkVal("midrst_busy", oBusy, 0);
      checkVal("midrst_ready", oReady, 1);
      checkVal("midrst_valid", oValid, 0);
      sawValid = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (oValid) sawValid = 1;
      end
      checkVal("midrst_no_valid", sawValid, 0);
      runReq(10, 22, 1, 0);

`ifdef MOD_POW4_SEQ_ABORT_EN
      iValid = 1'b1;
      iData = 8'd10;
      iQ = 8'd23;
      iExp = 4'd10;
      tick();
      iValid = 1'b0;
      tick();
      tick();
      iAbort = 1'b1;
      tick();
      iAbort = 1'b0;
      checkVal("abort_busy", oBusy, 0);
      checkVal("abort_valid", oValid, 0);
      checkVal("abort_ready", oReady, 1);
      sawValid = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (oValid) sawValid = 1;
      end
      checkVal("abort_no_valid", sawValid, 0);
      iAbort = 1'b1;
      tick();
      iAbort = 1'b0;
      runReq(10, 23, 3, 0);
`endif

      for (int n = 0; n < 30; n++) begin
         q = int'($urandom_range(0, 255));
         if (q >= 2 && ($urandom_range(0, 7) != 0))
            x = int'($urandom_range(0, q - 1));
         else
            x = int'($urandom_range(0, 255));
         k = int'($urandom_range(0, 15));
         runReq(x, q, k, int'($urandom_range(0, 3)));
      end

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule
